// File: rtl/cube_timer_if.sv
// cube_timer_if: button/tick inputs and phase/result outputs of the
// speedcubing timer phase controller.
//   tick        - one-cycle strobe, one per centisecond
//   button      - debounced, synchronised button level (1 = pressed)
//   state       - phase: 0 IDLE, 1 INSPECT, 2 HOLD, 3 READY, 4 TIMING, 5 STOPPED
//   ready       - high only in READY
//   elapsed     - solve time in ticks
//   inspect_cnt - inspection ticks used
//   penalty     - 0 none, 1 +2, 2 DNF
//   done        - one-cycle pulse on entry to STOPPED
// master drives tick/button (button front end), slave is the controller.
interface cube_timer_if #(
    parameter int TIME_W = 20
);
    logic              tick;
    logic              button;
    logic [2:0]        state;
    logic              ready;
    logic [TIME_W-1:0] elapsed;
    logic [TIME_W-1:0] inspect_cnt;
    logic [1:0]        penalty;
    logic              done;

    modport master (
        output tick, button,
        input  state, ready, elapsed, inspect_cnt, penalty, done
    );

    modport slave (
        input  tick, button,
        output state, ready, elapsed, inspect_cnt, penalty, done
    );
endinterface

// File: rtl/cube_timer_ctrl.sv
// cube_timer_ctrl: button-driven phase sequencer for a speedcubing timer.
// Optional timed inspection, hold-to-arm, timing and stopped phases, all
// advanced by an external centisecond tick; applies +2 / DNF inspection
// penalties.
//   clock - system clock
//   reset - synchronous, active-high
//   bus   - cube_timer_if.slave (tick, button in; state, ready, elapsed,
//           inspect_cnt, penalty, done out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a press; results of last solve still shown
// INSPECT | inspection running, inspect_cnt counts ticks
// HOLD    | button held, hold_cnt counts toward HOLD_TICKS
// READY   | armed; release starts timing and latches the penalty
// TIMING  | elapsed counts ticks; a press stops
// STOPPED | result frozen; a press returns to IDLE
module cube_timer_ctrl #(
    parameter bit INSPECT_EN    = 1'b1,
    parameter int INSPECT_TICKS = 1500,
    parameter int PENALTY_TICKS = 200,
    parameter int HOLD_TICKS    = 50,
    parameter int TIME_W        = 20
) (
    input logic         clock,
    input logic         reset,
    cube_timer_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INSPECT = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_READY   = 3'd3;
    localparam logic [2:0] S_TIMING  = 3'd4;
    localparam logic [2:0] S_STOPPED = 3'd5;

    localparam int                HOLD_W   = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_TICKS);
    localparam logic [TIME_W-1:0] CNT_MAX  = '1;
    localparam logic [TIME_W-1:0] PEN_LIM  = TIME_W'(INSPECT_TICKS);
    localparam logic [TIME_W-1:0] DNF_LIM  = TIME_W'(INSPECT_TICKS + PENALTY_TICKS);

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [TIME_W-1:0] elapsed_q, elapsed_d;
    logic [TIME_W-1:0] inspect_cnt_q, inspect_cnt_d;
    logic [1:0]        penalty_q, penalty_d;
    logic              done_q, done_d;
    logic              btn_q, btn_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic              rise, fall, insp_active;
    logic [TIME_W-1:0] insp_inc;
    logic [HOLD_W-1:0] hold_inc;

    always_comb begin
        btn_d       = bus.button;
        rise        = bus.button & ~btn_q;
        fall        = ~bus.button & btn_q;
        insp_active = INSPECT_EN &&
                      (state_q == S_INSPECT || state_q == S_HOLD || state_q == S_READY);
        insp_inc    = (inspect_cnt_q == CNT_MAX) ? inspect_cnt_q : inspect_cnt_q + TIME_W'(1);
        hold_inc    = hold_cnt_q + HOLD_W'(1);

        state_d       = state_q;
        elapsed_d     = elapsed_q;
        inspect_cnt_d = inspect_cnt_q;
        penalty_d     = penalty_q;
        hold_cnt_d    = hold_cnt_q;
        done_d        = 1'b0;

        // inspection keeps running underneath HOLD and READY
        if (insp_active && bus.tick) begin
            inspect_cnt_d = insp_inc;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    elapsed_d = '0;
                    penalty_d = 2'd0;
                    if (INSPECT_EN) begin
                        state_d       = S_INSPECT;
                        inspect_cnt_d = '0;
                    end else begin
                        state_d    = S_HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            S_INSPECT: begin
                if (rise) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                // a release wins over the tick that would have armed
                if (fall) begin
                    state_d = INSPECT_EN ? S_INSPECT : S_IDLE;
                end else if (bus.tick) begin
                    hold_cnt_d = hold_inc;
                    if (hold_inc == HOLD_LIM) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (fall) begin
                    state_d   = S_TIMING;
                    elapsed_d = '0;
                    penalty_d = (!INSPECT_EN || inspect_cnt_q < PEN_LIM) ? 2'd0 : 2'd1;
                end
            end
            S_TIMING: begin
                if (bus.tick && elapsed_q != CNT_MAX) begin
                    elapsed_d = elapsed_q + TIME_W'(1);
                end
                if (rise) begin
                    state_d = S_STOPPED;
                    done_d  = 1'b1;
                end
            end
            S_STOPPED: begin
                if (rise) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // running out of inspection overrides any button event this cycle
        if (insp_active && inspect_cnt_d >= DNF_LIM) begin
            state_d   = S_STOPPED;
            penalty_d = 2'd2;
            elapsed_d = '0;
            done_d    = 1'b1;
        end

        ready_d = (state_d == S_READY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ready_q       <= 1'b0;
            elapsed_q     <= '0;
            inspect_cnt_q <= '0;
            penalty_q     <= 2'd0;
            done_q        <= 1'b0;
            btn_q         <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            elapsed_q     <= elapsed_d;
            inspect_cnt_q <= inspect_cnt_d;
            penalty_q     <= penalty_d;
            done_q        <= done_d;
            btn_q         <= btn_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.ready       = ready_q;
    assign bus.elapsed     = elapsed_q;
    assign bus.inspect_cnt = inspect_cnt_q;
    assign bus.penalty     = penalty_q;
    assign bus.done        = done_q;
endmodule

// File: doc/cube_timer_ctrl.md
Name: cube_timer_ctrl

Overview:
Parametrised phase controller for the speedcubing timer. It replaces the plain four-phase cycler with a button-driven sequencer: optional timed inspection, hold-to-arm, timing and stopped phases. It runs on an external centisecond tick and applies inspection penalties (+2 / DNF). It sits between the synchronised/debounced button input and the display/segment driver logic.

Parameters:
INSPECT_EN, 1, 1 = inspection phase enabled; 0 = IDLE goes straight to hold-to-arm.
INSPECT_TICKS, 1500, inspection allowance in ticks (15.00 s).
PENALTY_TICKS, 200, grace window after the allowance that incurs +2 (2.00 s); beyond it is DNF.
HOLD_TICKS, 50, ticks the button must be held before arming (0.50 s). Must be ≥1.
TIME_W, 20, width of the elapsed and inspection counters.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
tick  in  1  one-cycle strobe, one per centisecond.
button  in  1  debounced, synchronised button level (1 = pressed).
state  out  3  phase: 0 IDLE, 1 INSPECT, 2 HOLD, 3 READY, 4 TIMING, 5 STOPPED.
ready  out  1  high only in READY (release starts timing).
elapsed  out  TIME_W  solve time in ticks.
inspect_cnt  out  TIME_W  inspection ticks used.
penalty  out  2  0 none, 1 +2, 2 DNF; 3 never driven.
done  out  1  one-cycle pulse on entry to STOPPED.

Behaviour:
- Clock is the only clock. Reset is synchronous and active-high and has priority over everything. Reset values: state=IDLE, ready=0, elapsed=0, inspect_cnt=0, penalty=0, done=0, internal btn_q=0, hold_cnt=0.
- Edge detection uses a registered btn_q: rise = button & ~btn_q, fall = ~button & btn_q. A button held through reset produces a rise on the first cycle after reset.
- IDLE:
  - rise with INSPECT_EN=1 → INSPECT; clears inspect_cnt, elapsed and penalty.
  - rise with INSPECT_EN=0 → HOLD; clears elapsed and penalty, and sets hold_cnt=0.
- INSPECT: inspect_cnt increments on each tick, saturating at 2^TIME_W-1. rise → HOLD with hold_cnt=0.
- HOLD:
  - hold_cnt increments on tick.
  - hold_cnt reaching HOLD_TICKS → READY. The transition happens in the same cycle as the tick that makes hold_cnt equal to HOLD_TICKS.
  - fall before that → INSPECT, or IDLE if INSPECT_EN=0.
  - inspect_cnt keeps counting during HOLD and READY.
- READY: fall → TIMING. elapsed is set to 0 on that cycle; a tick in the same cycle is not counted. Penalty is latched at this transition from inspect_cnt:
  - inspect_cnt < INSPECT_TICKS → 0.
  - otherwise, inspect_cnt < INSPECT_TICKS+PENALTY_TICKS → 1.
  - With INSPECT_EN=0, penalty = 0.
- DNF: if INSPECT_EN=1 and inspect_cnt reaches INSPECT_TICKS+PENALTY_TICKS while in INSPECT, HOLD or READY:
  - go to STOPPED with penalty=2, elapsed=0, done=1 for one cycle.
  - This overrides any button event in the same cycle.
- TIMING:
  - elapsed increments on tick, saturating at 2^TIME_W-1 (no wrap).
  - rise → STOPPED with done=1 for one cycle. A tick in the same cycle as the stopping rise is counted, so elapsed includes it.
  - fall is ignored.
- STOPPED: elapsed, penalty and inspect_cnt hold. rise → IDLE. Outputs keep their values until the next IDLE exit clears them.
- ready = (state==READY), registered with the state. done is registered.
- Events not listed for a state are ignored, including a tick with no counter running.
- Latency: state changes one clock after the button edge is visible on button.

Test Plan:
All scenarios use INSPECT_TICKS=10, PENALTY_TICKS=4, HOLD_TICKS=3, tick every cycle unless noted.
1. Reset with button=0, then idle 5 cycles → state=0, all outputs 0, done never pulses.
2. Clean solve:
   - Stimulus: press/release (IDLE→INSPECT), wait 4 ticks, press and hold ≥3 ticks, release, run 20 ticks, press.
   - Required: states go 1→2→3→4→5; penalty=0; elapsed=20 at STOPPED; done high exactly 1 cycle.
3. Early release: in HOLD release after 2 ticks → state returns to 1; inspect_cnt keeps counting with no reset.
4. +2 penalty: arm so the release from READY occurs with inspect_cnt=12 → penalty=1 latched; elapsed starts at 0.
5. DNF: hold in READY until inspect_cnt=14 → STOPPED, penalty=2, elapsed=0, done pulse; a simultaneous release is ignored.
6. Boundaries:
   - INSPECT_EN=0: IDLE press goes to state=2.
   - TIME_W=4 in TIMING: elapsed saturates at 15.
   - Reset asserted mid-TIMING → next cycle state=0, elapsed=0.
